hazard_tracker: RTL

- Per-frame object tracker directly downstream of the game progression FSM.
- Consumes its barrier and coin release lane codes, spawns one falling barrier and one falling coin, and moves each down the screen once per frame.
- Detects collisions against the penguin lane and jump state.
- Returns PENGUIN_HIT / COIN_HIT and ZERO_LIVES to the progression FSM, and drives the Y positions used by the sprite renderer.

---
 rtl/hazard_tracker.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/hazard_tracker.sv
// Falling-object tracker: one barrier channel and one coin channel, each spawned
// from a release lane code, advanced once per frame, and checked for collision
// against the penguin. Lives, coin count and the zero-lives flag live here too.

module hazard_channel #(
  parameter int          SPAWN_Y     = 0,
  parameter int          SPEED       = 2,
  parameter int          HIT_Y_MIN   = 400,
  parameter int          HIT_Y_MAX   = 440,
  parameter int          Y_LIMIT     = 480,
  parameter bit          JUMP_BLOCKS = 1'b0
) (
  input  logic       i_v_sync,
  input  logic       i_rst_n,
  input  logic       run,
  input  logic       kill,
  input  logic [1:0] code,
  input  logic [1:0] penguin_lane,
  input  logic       penguin_jump,
  output logic [9:0] y,
  output logic [1:0] lane,
  output logic       valid,
  output logic       hit,
  output logic       hit_now
);

  typedef enum logic [1:0] {ST_IDLE, ST_FALLING, ST_DONE} state_t;

  localparam logic [10:0] SPAWN_W = 11'(SPAWN_Y);
  localparam logic [10:0] SPEED_W = 11'(SPEED);
  localparam logic [10:0] MIN_W   = 11'(HIT_Y_MIN);
  localparam logic [10:0] MAX_W   = 11'(HIT_Y_MAX);
  localparam logic [10:0] LIMIT_W = 11'(Y_LIMIT);

  state_t      state_reg, state_next;
  logic [9:0]  y_reg, y_next;
  logic [1:0]  lane_reg, lane_next;
  logic        hit_reg, hit_next;
  logic [10:0] y_sum;
  logic        in_window;
  logic        lane_match;
  logic        jump_ok;

  // Collision is judged on the registered position of the current frame.
  assign y_sum      = {1'b0, y_reg} + SPEED_W;
  assign in_window  = ({1'b0, y_reg} >= MIN_W) && ({1'b0, y_reg} <= MAX_W);
  assign lane_match = (lane_reg == penguin_lane) && (penguin_lane != 2'b00);
  assign jump_ok    = JUMP_BLOCKS ? ~penguin_jump : 1'b1;
  assign hit_now    = run && (state_reg == ST_FALLING) && in_window && lane_match && jump_ok;

  // State register: channel state, position, latched lane and hit pulse.
  always_ff @(posedge i_v_sync) begin
    if (!i_rst_n) begin
      state_reg <= ST_IDLE;
      y_reg     <= SPAWN_W[9:0];
      lane_reg  <= 2'b00;
      hit_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      y_reg     <= y_next;
      lane_reg  <= lane_next;
      hit_reg   <= hit_next;
    end
  end

  // Next-state logic: spawn, fall, hit/miss, and re-arm on a new code.
  always_comb begin
    state_next = state_reg;
    y_next     = y_reg;
    lane_next  = lane_reg;
    hit_next   = 1'b0;
    if (run) begin
      case (state_reg)
        ST_IDLE: begin
          if (code != 2'b00) begin
            state_next = ST_FALLING;
            lane_next  = code;
            y_next     = SPAWN_W[9:0];
          end
        end
        ST_FALLING: begin
          if (hit_now) begin
            hit_next   = 1'b1;
            state_next = ST_DONE;
          end else if (y_sum > LIMIT_W) begin
            state_next = ST_DONE;
          end else begin
            y_next = y_sum[9:0];
          end
        end
        ST_DONE: begin
          // A held release never respawns; only a changed code does.
          if (code != lane_reg) begin
            if (code == 2'b00) begin
              state_next = ST_IDLE;
            end else begin
              state_next = ST_FALLING;
              lane_next  = code;
              y_next     = SPAWN_W[9:0];
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
    // Running out of lives clears any object in flight on the same edge.
    if (kill) begin
      state_next = ST_IDLE;
    end
  end

  // Output logic: valid only while falling; hit is the registered pulse.
  always_comb begin
    valid = (state_reg == ST_FALLING);
    hit   = hit_reg;
    y     = y_reg;
    lane  = lane_reg;
  end

endmodule

module hazard_tracker #(
  parameter int SPAWN_Y    = 0,
  parameter int SPEED      = 2,
  parameter int HIT_Y_MIN  = 400,
  parameter int HIT_Y_MAX  = 440,
  parameter int Y_LIMIT    = 480,
  parameter int INIT_LIVES = 3
) (
  input  logic       i_v_sync,
  input  logic       i_rst_n,
  input  logic       GAME_SWITCH,
  input  logic [1:0] RELEASE_BARRIER,
  input  logic [1:0] RELEASE_COIN,
  input  logic [1:0] PENGUIN_LANE,
  input  logic       PENGUIN_JUMP,
  output logic       PENGUIN_HIT,
  output logic       COIN_HIT,
  output logic       ZERO_LIVES,
  output logic [1:0] LIVES,
  output logic [7:0] COIN_COUNT,
  output logic [9:0] BARRIER_Y,
  output logic       BARRIER_VALID,
  output logic [1:0] BARRIER_LANE,
  output logic [9:0] COIN_Y,
  output logic       COIN_VALID,
  output logic [1:0] COIN_LANE
);

  // Channel 0 is the barrier, channel 1 is the coin.
  logic [1:0][1:0] code_vec;
  logic [1:0][9:0] y_vec;
  logic [1:0][1:0] lane_vec;
  logic [1:0]      valid_vec;
  logic [1:0]      hit_vec;
  logic [1:0]      hit_now_vec;

  logic       run;
  logic       kill;
  logic [1:0] lives_reg, lives_next;
  logic [7:0] coin_count_reg, coin_count_next;
  logic       zero_lives_reg, zero_lives_next;

  assign code_vec[0] = RELEASE_BARRIER;
  assign code_vec[1] = RELEASE_COIN;
  assign run         = GAME_SWITCH & ~zero_lives_reg;
  assign kill        = zero_lives_next & ~zero_lives_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      hazard_channel #(
        .SPAWN_Y     (SPAWN_Y),
        .SPEED       (SPEED),
        .HIT_Y_MIN   (HIT_Y_MIN),
        .HIT_Y_MAX   (HIT_Y_MAX),
        .Y_LIMIT     (Y_LIMIT),
        .JUMP_BLOCKS (gi == 0)
      ) u_chan (
        .i_v_sync     (i_v_sync),
        .i_rst_n      (i_rst_n),
        .run          (run),
        .kill         (kill),
        .code         (code_vec[gi]),
        .penguin_lane (PENGUIN_LANE),
        .penguin_jump (PENGUIN_JUMP),
        .y            (y_vec[gi]),
        .lane         (lane_vec[gi]),
        .valid        (valid_vec[gi]),
        .hit          (hit_vec[gi]),
        .hit_now      (hit_now_vec[gi])
      );
    end
  endgenerate

  // Lives and coins update on the same edge that launches the hit pulse.
  always_comb begin
    lives_next      = lives_reg;
    coin_count_next = coin_count_reg;
    if (hit_now_vec[0] && (lives_reg != 2'd0)) begin
      lives_next = lives_reg - 2'd1;
    end
    if (hit_now_vec[1] && (coin_count_reg != 8'hFF)) begin
      coin_count_next = coin_count_reg + 8'd1;
    end
    zero_lives_next = zero_lives_reg | (lives_next == 2'd0);
  end

  // Score registers; zero-lives is sticky until reset.
  always_ff @(posedge i_v_sync) begin
    if (!i_rst_n) begin
      lives_reg      <= 2'(INIT_LIVES);
      coin_count_reg <= 8'd0;
      zero_lives_reg <= 1'b0;
    end else begin
      lives_reg      <= lives_next;
      coin_count_reg <= coin_count_next;
      zero_lives_reg <= zero_lives_next;
    end
  end

  assign PENGUIN_HIT   = hit_vec[0];
  assign COIN_HIT      = hit_vec[1];
  assign ZERO_LIVES    = zero_lives_reg;
  assign LIVES         = lives_reg;
  assign COIN_COUNT    = coin_count_reg;
  assign BARRIER_Y     = y_vec[0];
  assign BARRIER_VALID = valid_vec[0];
  assign BARRIER_LANE  = lane_vec[0];
  assign COIN_Y        = y_vec[1];
  assign COIN_VALID    = valid_vec[1];
  assign COIN_LANE     = lane_vec[1];

endmodule
